// File: rtl/eth_rx_pkg.sv
// Shared constants and FSM state type for the Ethernet receive preamble/SFD detector.
package eth_rx_pkg;

    localparam logic [7:0] ETH_PRE_BYTE     = 8'h55;
    localparam logic [7:0] ETH_SFD_BYTE     = 8'hD5;

    localparam int         DEF_MIN_PREAMBLE = 7;
    localparam int         DEF_MAX_PREAMBLE = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/eth_rx_lane_classifier.sv
// Combinational lane scan of one receive word: counts leading preamble lanes and
// classifies the first non-preamble lane as SFD or bad. Later lanes are ignored.
module eth_rx_lane_classifier
    import eth_rx_pkg::*;
#(
    parameter  int DATA_BYTES = 8,
    localparam int P_W        = $clog2(DATA_BYTES + 1),
    localparam int LANE_W     = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
    input  logic [8*DATA_BYTES-1:0] word_i,
    output logic [P_W-1:0]          p_o,
    output logic                    sfd_hit_o,
    output logic                    bad_hit_o,
    output logic [LANE_W-1:0]       s_o
);

    logic stop;

    // Walk lanes from lane 0 (first on the wire) until the first non-0x55 byte.
    always_comb begin
        p_o       = '0;
        sfd_hit_o = 1'b0;
        bad_hit_o = 1'b0;
        s_o       = '0;
        stop      = 1'b0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (!stop) begin
                if (word_i[8*i +: 8] == ETH_PRE_BYTE) begin
                    p_o = p_o + P_W'(1);
                end else begin
                    stop = 1'b1;
                    s_o  = LANE_W'(i);
                    if (word_i[8*i +: 8] == ETH_SFD_BYTE) begin
                        sfd_hit_o = 1'b1;
                    end else begin
                        bad_hit_o = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/eth_rx_preamble_sfd_detector.sv
// Preamble/SFD detector for an N-byte receive datapath. Checks the preamble length
// against min/max limits and reports start-of-frame with the SFD byte lane.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for a word whose lane 0 is 0x55
//   ST_HUNT   | preamble in progress, cnt_q = 0x55 bytes seen so far
//   ST_LOCKED | SFD accepted, payload flowing; wait for i_frame_end
module eth_rx_preamble_sfd_detector
    import eth_rx_pkg::*;
#(
    parameter  int DATA_BYTES   = 8,
    parameter  int MIN_PREAMBLE = DEF_MIN_PREAMBLE,
    parameter  int MAX_PREAMBLE = DEF_MAX_PREAMBLE,
    localparam int CNT_W        = $clog2(MAX_PREAMBLE + DATA_BYTES + 1),
    localparam int LANE_W       = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [8*DATA_BYTES-1:0] i_msg_word,
    input  logic                    i_msg_valid,
    input  logic                    i_frame_end,
    output logic                    o_sof,
    output logic [LANE_W-1:0]       o_sfd_lane,
    output logic [CNT_W-1:0]        o_preamble_len,
    output logic                    o_err_short,
    output logic                    o_err_long,
    output logic                    o_err_bad,
    output logic                    o_locked
);

    localparam int P_W = $clog2(DATA_BYTES + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sof_q, sof_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic                err_short_q, err_short_d;
    logic                err_long_q, err_long_d;
    logic                err_bad_q, err_bad_d;

    logic [P_W-1:0]      cls_p;
    logic                cls_sfd_hit;
    logic                cls_bad_hit;
    logic [LANE_W-1:0]   cls_s;

    logic [CNT_W-1:0]    total;
    logic [CNT_W-1:0]    cnt_full;
    logic                eval;

    eth_rx_lane_classifier #(
        .DATA_BYTES (DATA_BYTES)
    ) u_classifier (
        .word_i    (i_msg_word),
        .p_o       (cls_p),
        .sfd_hit_o (cls_sfd_hit),
        .bad_hit_o (cls_bad_hit),
        .s_o       (cls_s)
    );

    // Next-state, counter and output-pulse decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sof_d       = 1'b0;
        lane_d      = lane_q;
        len_d       = len_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        err_bad_d   = 1'b0;

        total    = cnt_q + CNT_W'(cls_s);
        cnt_full = cnt_q + CNT_W'(DATA_BYTES);
        // IDLE only wakes on a word that starts with preamble; cnt_q is 0 there,
        // so the same evaluation covers a preamble+SFD completing in one word.
        eval     = i_msg_valid &&
                   ((state_q == ST_HUNT) ||
                    ((state_q == ST_IDLE) && (i_msg_word[7:0] == ETH_PRE_BYTE)));

        case (state_q)
            ST_IDLE, ST_HUNT: begin
                if (eval) begin
                    if (cls_sfd_hit) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (total < CNT_W'(MIN_PREAMBLE)) begin
                            err_short_d = 1'b1;
                            len_d       = total;
                        end else if (total > CNT_W'(MAX_PREAMBLE)) begin
                            err_long_d  = 1'b1;
                        end else begin
                            sof_d   = 1'b1;
                            lane_d  = cls_s;
                            len_d   = total;
                            state_d = ST_LOCKED;
                        end
                    end else if (cls_bad_hit) begin
                        err_bad_d = 1'b1;
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                    end else if (cnt_full > CNT_W'(MAX_PREAMBLE)) begin
                        err_long_d = 1'b1;
                        state_d    = ST_IDLE;
                        cnt_d      = '0;
                    end else begin
                        cnt_d   = cnt_full;
                        state_d = ST_HUNT;
                    end
                end
            end
            ST_LOCKED: begin
                if (i_frame_end) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; reset aborts silently.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sof_q       <= 1'b0;
            lane_q      <= '0;
            len_q       <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_bad_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sof_q       <= sof_d;
            lane_q      <= lane_d;
            len_q       <= len_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            err_bad_q   <= err_bad_d;
        end
    end

    assign o_sof          = sof_q;
    assign o_sfd_lane     = lane_q;
    assign o_preamble_len = len_q;
    assign o_err_short    = err_short_q;
    assign o_err_long     = err_long_q;
    assign o_err_bad      = err_bad_q;
    assign o_locked       = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_eth_rx_preamble_sfd_detector.sv
// Directed bench for the preamble/SFD detector: one 8-bit serial instance and one
// 64-bit instance share the clock and reset.
module tb_eth_rx_preamble_sfd_detector;

    logic        clk;
    logic        reset;

    logic [7:0]  w1;
    logic        v1;
    logic        fe1;
    logic        sof1;
    logic [0:0]  lane1;
    logic [4:0]  len1;
    logic        es1, el1, eb1, lk1;

    logic [63:0] w8;
    logic        v8;
    logic        fe8;
    logic        sof8;
    logic [2:0]  lane8;
    logic [4:0]  len8;
    logic        es8, el8, eb8, lk8;

    int errors = 0;
    int checks = 0;

    eth_rx_preamble_sfd_detector #(
        .DATA_BYTES   (1),
        .MIN_PREAMBLE (7),
        .MAX_PREAMBLE (15)
    ) u_dut1 (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_msg_word     (w1),
        .i_msg_valid    (v1),
        .i_frame_end    (fe1),
        .o_sof          (sof1),
        .o_sfd_lane     (lane1),
        .o_preamble_len (len1),
        .o_err_short    (es1),
        .o_err_long     (el1),
        .o_err_bad      (eb1),
        .o_locked       (lk1)
    );

    eth_rx_preamble_sfd_detector #(
        .DATA_BYTES   (8),
        .MIN_PREAMBLE (7),
        .MAX_PREAMBLE (15)
    ) u_dut8 (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_msg_word     (w8),
        .i_msg_valid    (v8),
        .i_frame_end    (fe8),
        .o_sof          (sof8),
        .o_sfd_lane     (lane8),
        .o_preamble_len (len8),
        .o_err_short    (es8),
        .o_err_long     (el8),
        .o_err_bad      (eb8),
        .o_locked       (lk8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are changed 1 ns after an edge; outputs are sampled 1 ns after the next.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [7:0] b);
        w1 = b;
        v1 = 1'b1;
        cyc();
        v1 = 1'b0;
    endtask

    task automatic send8(input logic [63:0] w);
        w8 = w;
        v8 = 1'b1;
        cyc();
        v8 = 1'b0;
    endtask

    task automatic end1();
        fe1 = 1'b1;
        cyc();
        fe1 = 1'b0;
    endtask

    task automatic end8();
        fe8 = 1'b1;
        cyc();
        fe8 = 1'b0;
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        w1 = '0; v1 = 1'b0; fe1 = 1'b0;
        w8 = '0; v8 = 1'b0; fe8 = 1'b0;
        cyc();
        cyc();
        chk("rst_sof1", sof1, 0);
        chk("rst_lk1", lk1, 0);
        chk("rst_len1", len1, 0);
        chk("rst_err1", {es1, el1, eb1}, 0);
        chk("rst_sof8", sof8, 0);
        chk("rst_lk8", lk8, 0);
        reset = 1'b0;
        cyc();

        // 8-bit: 7x 0x55 then SFD
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            send1(8'h55);
            pulses += int'(sof1) + int'(es1) + int'(el1) + int'(eb1);
        end
        chk("t1_no_pulse_in_preamble", pulses, 0);
        send1(8'hD5);
        chk("t1_sof", sof1, 1);
        chk("t1_len", len1, 7);
        chk("t1_lane", lane1, 0);
        chk("t1_locked", lk1, 1);
        cyc();
        chk("t1_sof_single", sof1, 0);
        chk("t1_locked_hold", lk1, 1);
        send1(8'h55);
        send1(8'hD5);
        chk("t1_no_redetect", sof1, 0);
        chk("t1_locked_still", lk1, 1);
        end1();
        chk("t1_unlock", lk1, 0);

        // 64-bit: whole preamble+SFD in one word, repeated while locked
        send8(64'hD555555555555555);
        chk("t2_sof", sof8, 1);
        chk("t2_len", len8, 7);
        chk("t2_lane", lane8, 7);
        chk("t2_locked", lk8, 1);
        send8(64'hD555555555555555);
        chk("t2_no_redetect", sof8, 0);
        chk("t2_locked_hold", lk8, 1);
        end8();
        chk("t2_unlock", lk8, 0);

        // 64-bit: full preamble word, gap, then SFD in lane 2
        send8(64'h5555555555555555);
        chk("t3_first_no_sof", sof8, 0);
        chk("t3_first_no_err", {es8, el8, eb8}, 0);
        cyc();
        chk("t3_gap_no_sof", sof8, 0);
        send8(64'h0000000000D55555);
        chk("t3_sof", sof8, 1);
        chk("t3_len", len8, 10);
        chk("t3_lane", lane8, 2);
        end8();
        chk("t3_unlock", lk8, 0);

        // 8-bit: short preamble
        for (int i = 0; i < 5; i++) send1(8'h55);
        send1(8'hD5);
        chk("t4_short", es1, 1);
        chk("t4_short_len", len1, 5);
        chk("t4_short_no_sof", sof1, 0);
        chk("t4_short_no_lock", lk1, 0);
        cyc();
        chk("t4_short_single", es1, 0);

        // 8-bit: bad byte inside preamble
        for (int i = 0; i < 3; i++) send1(8'h55);
        send1(8'h12);
        chk("t4_bad", eb1, 1);
        chk("t4_bad_no_sof", sof1, 0);
        cyc();
        chk("t4_bad_single", eb1, 0);

        // 8-bit: 16x 0x55 overruns MAX, then a good preamble recovers
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            send1(8'h55);
            pulses += int'(el1);
        end
        chk("t5_no_long_at_15", pulses, 0);
        send1(8'h55);
        chk("t5_long", el1, 1);
        chk("t5_long_no_sof", sof1, 0);
        for (int i = 0; i < 7; i++) send1(8'h55);
        chk("t5_long_single", el1, 0);
        send1(8'hD5);
        chk("t5_recover_sof", sof1, 1);
        chk("t5_recover_len", len1, 7);
        end1();

        // 8-bit: exactly MAX preamble bytes is still accepted
        for (int i = 0; i < 15; i++) send1(8'h55);
        send1(8'hD5);
        chk("t5_max_sof", sof1, 1);
        chk("t5_max_len", len1, 15);
        chk("t5_max_no_long", el1, 0);
        end1();

        // 8-bit: reset mid-hunt aborts silently
        for (int i = 0; i < 4; i++) send1(8'h55);
        reset = 1'b1;
        cyc();
        chk("t6_rst_sof", sof1, 0);
        chk("t6_rst_err", {es1, el1, eb1}, 0);
        chk("t6_rst_lk", lk1, 0);
        chk("t6_rst_len", len1, 0);
        reset = 1'b0;
        cyc();
        chk("t6_after_rst_err", {es1, el1, eb1}, 0);
        for (int i = 0; i < 7; i++) send1(8'h55);
        send1(8'hD5);
        chk("t6_sof", sof1, 1);
        chk("t6_len", len1, 7);
        end1();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
